// File: rtl/mem_copy_engine.sv
// Block-copy master for the 16-bit data memory: reads a word, writes it, repeats; picks direction for overlaps.
// Optional running checksum of copied words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
    parameter int ADR_W     = 10,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADR_W-1:0]  src,
    input  logic [ADR_W-1:0]  dst,
    input  logic [ADR_W:0]    len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_out
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // Handshake: start is a one-cycle request honoured only in IDLE; exactly one of done/err
    // pulses for each accepted request, and busy covers the memory-owning cycles in between.
    localparam int EXT_W = ADR_W + 2;

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    state_t             state;
    logic [ADR_W-1:0]   cur_src;
    logic [ADR_W-1:0]   cur_dst;
    logic [ADR_W:0]     remaining;
    logic               descending;

    logic [EXT_W-1:0]   src_end;
    logic [EXT_W-1:0]   dst_end;
    logic               req_bad;
    logic               req_desc;
    logic [ADR_W-1:0]   first_src;
    logic [ADR_W-1:0]   first_dst;
    logic [ADR_W-1:0]   next_src;
    logic [ADR_W-1:0]   next_dst;

    // Extended-width sums so an oversized request cannot wrap into a legal-looking range.
    assign src_end   = EXT_W'(src) + EXT_W'(len);
    assign dst_end   = EXT_W'(dst) + EXT_W'(len);
    assign req_bad   = (src_end > EXT_W'(MEM_DEPTH)) || (dst_end > EXT_W'(MEM_DEPTH));
    assign req_desc  = (dst > src) && (EXT_W'(dst) < src_end);
    assign first_src = req_desc ? src + ADR_W'(len) - 1'b1 : src;
    assign first_dst = req_desc ? dst + ADR_W'(len) - 1'b1 : dst;
    assign next_src  = descending ? cur_src - 1'b1 : cur_src + 1'b1;
    assign next_dst  = descending ? cur_dst - 1'b1 : cur_dst + 1'b1;

    // mem_data doubles as the word buffer: it is loaded at the end of READ and held through WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_adr    <= '0;
            mem_data   <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            descending <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (req_bad) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            busy       <= 1'b1;
                            mem_read   <= 1'b1;
                            mem_adr    <= first_src;
                            cur_src    <= first_src;
                            cur_dst    <= first_dst;
                            descending <= req_desc;
                            remaining  <= len;
                        end
                    end
                end
                READ: begin
                    state     <= WRITE;
                    mem_data  <= mem_out;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_adr   <= cur_dst;
                end
                WRITE: begin
                    mem_write <= 1'b0;
                    remaining <= remaining - 1'b1;
                    cur_src   <= next_src;
                    cur_dst   <= next_dst;
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum  <= checksum + mem_data;
`endif
                    if (remaining == (ADR_W+1)'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= READ;
                        mem_read <= 1'b1;
                        mem_adr  <= next_src;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural memmove model, write-order scoreboard, timing checks.
module tb_mem_copy_engine;

    localparam int ADR_W  = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADR_W-1:0]  src;
    logic [ADR_W-1:0]  dst;
    logic [ADR_W:0]    len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_out;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] mem   [0:DEPTH-1];
    logic [DATA_W-1:0] model [0:DEPTH-1];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADR_W-1:0]  wadr_q[$];
    logic [ADR_W-1:0]  radr_q[$];
    logic [DATA_W-1:0] exp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    mem_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_adr   (mem_adr),
        .mem_data  (mem_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_out   (mem_out)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_out = (mem_read && int'(mem_adr) < DEPTH) ? mem[mem_adr] : 16'h0;

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = 16'($urandom);
            model[i] = mem[i];
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s mem: %0d words differ, first at %0d got %h want %h",
                     name, bad, first, mem[first], model[first]);
        end
    endtask

    task automatic check_checksum(input string name, input logic [DATA_W-1:0] want);
`ifdef MEM_COPY_CHECKSUM_EN
        n_checks++;
        if (checksum !== want) begin
            n_fail++;
            $display("FAIL %s checksum: got %h want %h", name, checksum, want);
        end
`else
        if (want === 16'hxxxx) $display("unused %s", name);
`endif
    endtask

    // Expectations come from the memmove rule: snapshot the source block, then write it to dst.
    task automatic run_copy(input string name, input int s, input int d, input int l, input bit poke);
        logic [DATA_W-1:0] tmp[$];
        bit exp_err, desc, got_err;
        int exp_cycle, end_cycle, reads, writes, busy_bad, both;
        exp_err   = (s + l > DEPTH) || (d + l > DEPTH);
        desc      = (d > s) && (d < s + l);
        exp_cycle = (exp_err || l == 0) ? 1 : 2 * l + 1;
        exp_q.delete(); wadr_q.delete(); radr_q.delete();
        exp_sum = '0;
        if (!exp_err) begin
            for (int i = 0; i < l; i++) tmp.push_back(model[s + i]);
            for (int k = 0; k < l; k++) begin
                int idx = desc ? l - 1 - k : k;
                exp_q.push_back(tmp[idx]);
                wadr_q.push_back(ADR_W'(d + idx));
                radr_q.push_back(ADR_W'(s + idx));
                exp_sum = exp_sum + tmp[idx];
            end
            for (int i = 0; i < l; i++) model[d + i] = tmp[i];
        end

        @(negedge clk);
        src = ADR_W'(s); dst = ADR_W'(d); len = (ADR_W+1)'(l); start = 1'b1;
        end_cycle = -1; got_err = 0; reads = 0; writes = 0; busy_bad = 0; both = 0;
        for (int k = 1; k <= exp_cycle + 8 && end_cycle < 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke && k == 3) begin
                src = ADR_W'($urandom_range(0, 500)); dst = ADR_W'($urandom_range(0, 500));
                len = 11'd1; start = 1'b1;
            end
            if (poke && k == 4) start = 1'b0;
            if (mem_read && mem_write) both++;
            if (mem_read) begin
                reads++;
                n_checks++;
                if (radr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s read_adr: unexpected read at %0d", name, mem_adr);
                end else begin
                    logic [ADR_W-1:0] ra = radr_q.pop_front();
                    if (mem_adr !== ra) begin
                        n_fail++;
                        $display("FAIL %s read_adr: got %0d want %0d", name, mem_adr, ra);
                    end
                end
            end
            if (mem_write) begin
                writes++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s write: unexpected write at %0d", name, mem_adr);
                end else begin
                    logic [DATA_W-1:0] wd = exp_q.pop_front();
                    logic [ADR_W-1:0]  wa = wadr_q.pop_front();
                    if (mem_adr !== wa || mem_data !== wd) begin
                        n_fail++;
                        $display("FAIL %s write: got adr %0d data %h want adr %0d data %h",
                                 name, mem_adr, mem_data, wa, wd);
                    end
                end
                if (int'(mem_adr) < DEPTH) mem[mem_adr] = mem_data;
            end
            if (done || err) begin
                end_cycle = k;
                got_err   = err;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        start = 1'b0;

        n_checks++;
        if (end_cycle != exp_cycle) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, end_cycle, exp_cycle);
        end
        n_checks++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s result: got err=%0b want err=%0b", name, got_err, exp_err);
        end
        n_checks++;
        if (reads != (exp_err ? 0 : l) || writes != (exp_err ? 0 : l)) begin
            n_fail++;
            $display("FAIL %s strobes: got %0d reads %0d writes want %0d each",
                     name, reads, writes, exp_err ? 0 : l);
        end
        n_checks++;
        if (busy_bad != 0 || both != 0) begin
            n_fail++;
            $display("FAIL %s busy/overlap: got %0d busy errors %0d overlaps want 0", name, busy_bad, both);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
                n_fail++;
                $display("FAIL %s idle_after: got busy,done,err,rd,wr=%b want 00000",
                         name, {busy, done, err, mem_read, mem_write});
            end
        end
        check_mem(name);
        check_checksum(name, exp_err ? 16'h0 : exp_sum);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        fill_random();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, mem_read, mem_write, mem_adr, mem_data} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b want all zero",
                     {busy, done, err, mem_read, mem_write, mem_adr, mem_data});
        end
        check_checksum("reset", 16'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        for (int i = 0; i < 4; i++) begin
            mem[10 + i] = 16'(i + 1); model[10 + i] = 16'(i + 1);
        end
        run_copy("ascending", 10, 100, 4, 0);
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) begin
            mem[20 + i] = 16'hA + 16'(i); model[20 + i] = 16'hA + 16'(i);
        end
        run_copy("overlap_desc", 20, 22, 4, 0);
        run_copy("overlap_asc", 22, 20, 4, 0);
        run_copy("same_adr", 30, 30, 3, 0);
    endtask

    task automatic test_boundary();
        run_copy("edge_ok", 996, 0, 4, 0);
        run_copy("src_over", 997, 0, 4, 0);
        run_copy("dst_over", 5, 997, 4, 0);
        run_copy("len_zero", 50, 60, 0, 0);
        run_copy("full_mem", 0, 0, DEPTH, 0);
        run_copy("len_over", 0, 0, DEPTH + 1, 0);
    endtask

    task automatic test_busy_ignore();
        run_copy("busy_ignore", 200, 400, 6, 1);
    endtask

    task automatic test_reset_mid();
        int s = 300, d = 500;
        logic [DATA_W-1:0] w0;
        w0 = model[s];
        @(negedge clk);
        src = ADR_W'(s); dst = ADR_W'(d); len = 11'd5; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) begin
                n_checks++;
                if (mem_write !== 1'b1 || mem_adr !== ADR_W'(d + 1)) begin
                    n_fail++;
                    $display("FAIL reset_mid pre: got wr=%b adr=%0d want wr=1 adr=%0d", mem_write, mem_adr, d + 1);
                end
            end else if (mem_write && int'(mem_adr) < DEPTH) begin
                mem[mem_adr] = mem_data;
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid abort: got busy,done,rd,wr=%b want 0000", {busy, done, mem_read, mem_write});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_mid quiet: got %b want 00000", {busy, done, err, mem_read, mem_write});
            end
        end
        model[d] = w0;
        check_mem("reset_mid");
        check_checksum("reset_mid", 16'h0);
        run_copy("after_reset", 40, 700, 5, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int s, d, l, mode;
            s = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 24);
            mode = $urandom_range(0, 2);
            if (mode == 0) d = $urandom_range(0, 1023);
            else if (mode == 1) d = s + $urandom_range(0, 8);
            else d = s - $urandom_range(0, 8);
            if (d < 0) d = 0;
            if (d > 1023) d = 1023;
            run_copy($sformatf("random%0d", n), s, d, l, 0);
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_overlap();
        test_boundary();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side master for the 16-bit x 1000-word data memory port (adr/data/sig_write/sig_read/out).
- Copies a block of LEN words from SRC to DST: read one word, capture it, write it, repeat.
- Handles overlapping regions by choosing the copy direction.
- Shares the memory with the datapath through an external mux while busy=1.

Parameters:
- ADR_W, 10, memory address width.
- DATA_W, 16, memory word width.
- MEM_DEPTH, 1000, number of valid words (addresses 0..MEM_DEPTH-1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src  in  ADR_W  first source address.
- dst  in  ADR_W  first destination address.
- len  in  ADR_W+1  word count, 0..MEM_DEPTH.
- busy  out  1  high from the cycle after accepted start until DONE/ERR.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on rejected request.
- mem_adr  out  ADR_W  memory address.
- mem_data  out  DATA_W  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_out  in  DATA_W  memory read data, combinational from mem_adr while mem_read=1.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; busy, done, err, mem_read, mem_write = 0; mem_adr, mem_data = 0; internal counters and buffer = 0.
- States: IDLE, READ, WRITE, DONE, ERR. All outputs are registered.
- IDLE, start=1: evaluate the request in the same cycle.
  - If src+len > MEM_DEPTH or dst+len > MEM_DEPTH (computed at ADR_W+2 bits, no wrap): go to ERR.
  - Else if len=0: go to DONE.
  - Else: go to READ.
    - Direction: descending if dst > src and dst < src+len; otherwise ascending.
    - Ascending: cur_src=src, cur_dst=dst.
    - Descending: cur_src=src+len-1, cur_dst=dst+len-1.
    - remaining=len.
- IDLE, start=0: hold. start while busy=1 is ignored (no queuing).
- READ (1 cycle):
  - mem_read=1, mem_write=0, mem_adr=cur_src.
  - At the rising edge, buf <= mem_out. Go to WRITE.
- WRITE (1 cycle):
  - mem_read=0, mem_write=1, mem_adr=cur_dst, mem_data=buf.
  - At the edge: remaining decrements; cur_src/cur_dst step +1 (ascending) or -1 (descending).
  - Go to DONE if remaining was 1, else READ.
- mem_read and mem_write are never both 1 in the same cycle.
- Throughput: 2 cycles per word. Latency from start to done pulse = 2*len+1 cycles; 1 cycle when len=0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- ERR: err=1 and busy=0 for one cycle, then IDLE. Memory is not touched (no read or write strobe issued).
- Address arithmetic is ADR_W bits. Range checks guarantee no wrap-around within an accepted transfer.
- src=dst is accepted: words are rewritten with their own values.
- Reset mid-transfer: abort immediately, strobes drop asynchronously, no done pulse. Words already written stay written.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_W).
  - Cleared to 0 on reset and on each accepted start.
  - In WRITE, checksum <= checksum + buf, modulo 2^DATA_W.
  - Value is stable from the done pulse until the next accepted start.
  - On ERR, checksum is cleared to 0.
- Not defined: no checksum port and no adder; all other behaviour identical.

Test Plan:
- Ascending copy: preload mem[10..13]=1,2,3,4; src=10, dst=100, len=4 -> mem[100..103]=1,2,3,4; done pulses 9 cycles after start; checksum=10 when enabled.
- Overlap, descending: mem[20..23]=A,B,C,D; src=20, dst=22, len=4 -> mem[22..25]=A,B,C,D; first write address is 25.
- Overlap, ascending: same data; src=22, dst=20, len=4 -> mem[20..23] = original mem[22..25]; first write address is 20.
- Boundary and error: src=996, dst=0, len=4 -> accepted, done; src=997, len=4 -> err pulse 1 cycle after start, no strobes. len=0 -> done 1 cycle after start, no strobes.
- Reset mid-transfer: assert rst in the WRITE of word 2 of 5 -> strobes 0 immediately, busy=0, no done; next start operates normally.
- Protocol checks: start pulsed while busy=1 is ignored; mem_read and mem_write never both 1 (assertion); busy=1 exactly from start+1 to the cycle before done.
